// File: rtl/phase_unwrap.sv
// rtl/phase_unwrap.sv - wrapped-angle unwrapper with decimated phase-difference output (optional PHASE_UNWRAP_SAT_EN)
module phase_unwrap #(
    parameter int ACC_WIDTH = 32,
    parameter int DECIM     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 sink_valid,
    input  logic [15:0]          sink_phase,
    output logic                 source_valid,
    output logic [ACC_WIDTH-1:0] source_phase,
    output logic [ACC_WIDTH-1:0] source_freq
);

    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
    localparam logic signed [16:0] PI     = 17'sd25736;
    localparam logic signed [16:0] TWO_PI = 17'sd51472;

    typedef enum logic {EMPTY, RUN} state_t;

    state_t                state;
    state_t                state_next;
    logic                  take_delta;
    logic [15:0]           prev;
    logic signed [16:0]    d_raw;
    logic signed [16:0]    d_wrap;
    logic [ACC_WIDTH-1:0]  d1;
    logic                  v1;
    logic [ACC_WIDTH-1:0]  acc;
    logic [ACC_WIDTH-1:0]  sum;
    logic [CNT_W-1:0]      cnt;
    logic [ACC_WIDTH-1:0]  acc_n;
    logic [ACC_WIDTH-1:0]  sum_n;

`ifdef PHASE_UNWRAP_SAT_EN
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    logic                  acc_sat;
    logic                  acc_sat_n;
    logic [ACC_WIDTH:0]    acc_wide;
    logic [ACC_WIDTH:0]    sum_wide;
`endif

    // Reference-sample FSM register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next state: clear drops history but a coincident sample becomes the new reference
    always_comb begin
        state_next = state;
        take_delta = 1'b0;
        if (clear) begin
            state_next = sink_valid ? RUN : EMPTY;
        end else if (sink_valid) begin
            state_next = RUN;
            take_delta = (state == RUN);
        end
    end

    // Wrapped difference folded back into [-pi, +pi]; exactly +/-pi is left alone
    always_comb begin
        d_raw  = $signed({sink_phase[15], sink_phase}) - $signed({prev[15], prev});
        d_wrap = d_raw;
        if (d_raw > PI) begin
            d_wrap = d_raw - TWO_PI;
        end else if (d_raw < -PI) begin
            d_wrap = d_raw + TWO_PI;
        end
    end

    // Stage 1: latch reference and the folded delta
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
            d1   <= '0;
            v1   <= 1'b0;
        end else begin
            if (sink_valid) begin
                prev <= sink_phase;
            end
            if (take_delta) begin
                d1 <= {{(ACC_WIDTH-17){d_wrap[16]}}, d_wrap};
            end
            v1 <= take_delta && !clear;
        end
    end

    // Next accumulator and window-sum values (modular or saturating)
    always_comb begin
`ifdef PHASE_UNWRAP_SAT_EN
        acc_wide  = {acc[ACC_WIDTH-1], acc} + {d1[ACC_WIDTH-1], d1};
        sum_wide  = {sum[ACC_WIDTH-1], sum} + {d1[ACC_WIDTH-1], d1};
        acc_sat_n = acc_sat;
        if (acc_sat) begin
            acc_n = acc;
        end else if (acc_wide[ACC_WIDTH] != acc_wide[ACC_WIDTH-1]) begin
            acc_n     = acc_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
            acc_sat_n = 1'b1;
        end else begin
            acc_n = acc_wide[ACC_WIDTH-1:0];
        end
        if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]) begin
            sum_n = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            sum_n = sum_wide[ACC_WIDTH-1:0];
        end
`else
        acc_n = acc + d1;
        sum_n = sum + d1;
`endif
    end

    // Stage 2: accumulate, and publish every DECIM-th delta
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            sum          <= '0;
            cnt          <= '0;
            source_valid <= 1'b0;
            source_phase <= '0;
            source_freq  <= '0;
        end else if (clear) begin
            acc          <= '0;
            sum          <= '0;
            cnt          <= '0;
            source_valid <= 1'b0;
        end else begin
            source_valid <= 1'b0;
            if (v1) begin
                acc <= acc_n;
                if (cnt == CNT_LAST) begin
                    source_phase <= acc_n;
                    source_freq  <= sum_n;
                    source_valid <= 1'b1;
                    sum          <= '0;
                    cnt          <= '0;
                end else begin
                    sum <= sum_n;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

`ifdef PHASE_UNWRAP_SAT_EN
    // Sticky saturation flag, released only by reset or clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_sat <= 1'b0;
        end else if (clear) begin
            acc_sat <= 1'b0;
        end else if (v1) begin
            acc_sat <= acc_sat_n;
        end
    end
`endif

endmodule

// File: tb/tb_phase_unwrap.sv
// tb/tb_phase_unwrap.sv - directed self-checking bench for phase_unwrap
module tb_phase_unwrap;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        sink_valid = 1'b0;
    logic [15:0] sink_phase = '0;

    logic               v4, v1, vw;
    logic signed [31:0] ph4, fr4, ph1, fr1;
    logic signed [19:0] phw, frw;

    int checks = 0;
    int failures = 0;
    int n4 = 0;
    int n1 = 0;
    int nw = 0;

    always #5 clk = ~clk;

    phase_unwrap #(.ACC_WIDTH(32), .DECIM(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .sink_valid(sink_valid),
        .sink_phase(sink_phase), .source_valid(v4), .source_phase(ph4), .source_freq(fr4));

    phase_unwrap #(.ACC_WIDTH(32), .DECIM(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .sink_valid(sink_valid),
        .sink_phase(sink_phase), .source_valid(v1), .source_phase(ph1), .source_freq(fr1));

    phase_unwrap #(.ACC_WIDTH(20), .DECIM(1)) u_w20 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .sink_valid(sink_valid),
        .sink_phase(sink_phase), .source_valid(vw), .source_phase(phw), .source_freq(frw));

    // Count output strobes just after each rising edge
    always @(posedge clk) begin
        #1;
        if (v4) n4++;
        if (v1) n1++;
        if (vw) nw++;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [15:0] p, input logic clr);
        sink_valid = 1'b1;
        sink_phase = p;
        clear      = clr;
        @(negedge clk);
        sink_valid = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        longint tot;
        longint expv;
        logic signed [19:0] w;
        int p;

        // Reset state
        idle(3);
        check("rst_ph4", ph4, 0);
        check("rst_fr4", fr4, 0);
        check("rst_v4", v4, 0);
        rst_n = 1'b1;
        idle(5);
        check("idle_ph1", ph1, 0);
        check("idle_phw", phw, 0);
        check("idle_n4", n4, 0);
        check("idle_n1", n1, 0);
        check("idle_nw", nw, 0);

        // DECIM=4 ramp
        do_clear();
        n4 = 0;
        drive(16'h0000, 1'b0);
        drive(16'h0100, 1'b0);
        drive(16'h0200, 1'b0);
        drive(16'h0300, 1'b0);
        drive(16'h0400, 1'b0);
        check("ramp_lat1_v4", v4, 0);
        idle(1);
        check("ramp_lat2_v4", v4, 1);
        check("ramp_ph4", ph4, 'h400);
        check("ramp_fr4", fr4, 'h400);
        idle(2);
        check("ramp_n4", n4, 1);

        // Crossing +pi
        do_clear();
        drive(16'h6000, 1'b0);
        drive(16'h9C00, 1'b0);
        idle(2);
        check("xpos_ph1", ph1, 1296);
        check("xpos_fr1", fr1, 1296);

        // Crossing -pi
        do_clear();
        drive(16'h9C00, 1'b0);
        drive(16'h6000, 1'b0);
        idle(2);
        check("xneg_ph1", ph1, -1296);
        check("xneg_fr1", fr1, -1296);

        // +pi/-pi boundaries and exactly-pi steps
        do_clear();
        drive(16'h6488, 1'b0);
        drive(16'h9B78, 1'b0);
        idle(1);
        check("bnd_pm_v1", v1, 1);
        check("bnd_pm_fr1", fr1, 0);
        drive(16'h6488, 1'b0);
        idle(1);
        check("bnd_mp_v1", v1, 1);
        check("bnd_mp_fr1", fr1, 0);
        drive(16'h0000, 1'b0);
        idle(1);
        check("bnd_negpi_fr1", fr1, -25736);
        check("bnd_negpi_ph1", ph1, -25736);
        drive(16'h6488, 1'b0);
        idle(1);
        check("bnd_pospi_fr1", fr1, 25736);
        check("bnd_pospi_ph1", ph1, 0);

        // clear together with a sample
        do_clear();
        drive(16'h0000, 1'b0);
        drive(16'h0800, 1'b0);
        idle(1);
        check("clr_pre_ph1", ph1, 'h800);
        drive(16'h1000, 1'b1);
        n1 = 0;
        check("clr_hold_ph1", ph1, 'h800);
        drive(16'h1100, 1'b0);
        idle(1);
        check("clr_ph1", ph1, 'h100);
        check("clr_fr1", fr1, 'h100);
        idle(2);
        check("clr_n1", n1, 1);

        // Reset mid-stream
        drive(16'h0100, 1'b0);
        drive(16'h0200, 1'b0);
        rst_n = 1'b0;
        idle(1);
        check("mrst_ph1", ph1, 0);
        check("mrst_v1", v1, 0);
        rst_n = 1'b1;
        drive(16'h0300, 1'b0);
        drive(16'h0380, 1'b0);
        idle(1);
        check("mrst_after_ph1", ph1, 'h80);

        // 20-bit accumulator with a constant +0x6000 unwrapped step
        do_clear();
        p = 0;
        tot = 0;
        drive(16'(p), 1'b0);
        for (int k = 1; k <= 24; k++) begin
            p = p + 24576;
            if (p > 25736) p = p - 51472;
            drive(16'(p), 1'b0);
            idle(1);
            tot = tot + 24576;
            w = tot[19:0];
`ifdef PHASE_UNWRAP_SAT_EN
            expv = (tot > 524287) ? 524287 : tot;
`else
            expv = w;
`endif
            check($sformatf("w20_ph_%0d", k), phw, expv);
            check($sformatf("w20_fr_%0d", k), frw, 24576);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
